// File: rtl/clock_set_controller.sv
// ============================================================================
// clock_set_controller: button-driven hour/minute set sequencer with blink.
// Optional auto-repeat on held inc/dec: define CLOCK_SET_AUTO_REPEAT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module clock_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned BLINK_CYCLES   = 500,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hours,
  input  logic [6:0] cur_minutes,
  output logic       set_strobe,
  output logic [4:0] set_hours,
  output logic [6:0] set_minutes,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned c_to_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned c_bl_w = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  if (TIMEOUT_CYCLES < 1 || BLINK_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("clock_set_controller: cycle-count parameters must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2,
    ST_COMMIT      = 2'd3
  } state_e;

  state_e             state_q;
  logic               set_strobe_q;
  logic [4:0]         set_hours_q;
  logic [6:0]         set_minutes_q;
  logic               blink_q;
  logic [c_to_w-1:0]  to_cnt_q;
  logic [c_bl_w-1:0]  blink_cnt_q;
  logic [2:0]         mode_sync_q, inc_sync_q, dec_sync_q;

  logic       w_mode_p, w_inc_p, w_dec_p, w_any_p;
  logic       w_edit;
  logic       w_rep_up, w_rep_dn;
  logic       w_step_up, w_step_dn;
  logic [5:0] w_h_up6;
  logic [7:0] w_m_up8;
  logic [4:0] w_h_up, w_h_dn, w_load_h;
  logic [6:0] w_m_up, w_m_dn, w_load_m;

  // Two synchronizer flops plus one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_sync_q <= 3'b000;
      inc_sync_q  <= 3'b000;
      dec_sync_q  <= 3'b000;
    end else begin
      mode_sync_q <= {mode_sync_q[1:0], btn_mode};
      inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
      dec_sync_q  <= {dec_sync_q[1:0], btn_dec};
    end
  end

  assign w_mode_p = mode_sync_q[1] & ~mode_sync_q[2];
  assign w_inc_p  = inc_sync_q[1] & ~inc_sync_q[2];
  assign w_dec_p  = dec_sync_q[1] & ~dec_sync_q[2];
  assign w_any_p  = w_inc_p | w_dec_p;
  assign w_edit   = (state_q == ST_SET_HOURS) || (state_q == ST_SET_MINUTES);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int unsigned c_rp_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned c_rp_w   = (c_rp_max > 1) ? $clog2(c_rp_max) : 1;

  logic [c_rp_w-1:0] rep_cnt_q;
  logic              rep_armed_q;
  logic              w_hold_up, w_hold_dn, w_rep_fire;

  assign w_hold_up  = w_edit & inc_sync_q[1] & ~dec_sync_q[1];
  assign w_hold_dn  = w_edit & dec_sync_q[1] & ~inc_sync_q[1];
  // Repeat only on plain held cycles; press and mode cycles have their own handling
  assign w_rep_fire = (w_hold_up | w_hold_dn) & ~w_any_p & ~w_mode_p &
                      (rep_armed_q ? (rep_cnt_q == c_rp_w'(REPEAT_RATE - 1))
                                   : (rep_cnt_q == c_rp_w'(REPEAT_DELAY - 1)));
  assign w_rep_up   = w_rep_fire & w_hold_up;
  assign w_rep_dn   = w_rep_fire & w_hold_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (!(w_hold_up || w_hold_dn) || w_mode_p || w_any_p) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (w_rep_fire) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end
`else
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  assign w_step_up = (w_inc_p & ~w_dec_p) | w_rep_up;
  assign w_step_dn = (w_dec_p & ~w_inc_p) | w_rep_dn;

  always_comb begin
    w_h_up6  = {1'b0, set_hours_q} + 6'd1;
    w_h_up   = (w_h_up6 >= 6'd24) ? 5'd0 : w_h_up6[4:0];
    w_h_dn   = (set_hours_q == 5'd0) ? 5'd23 : set_hours_q - 5'd1;
    w_m_up8  = {1'b0, set_minutes_q} + 8'd1;
    w_m_up   = (w_m_up8 >= 8'd60) ? 7'd0 : w_m_up8[6:0];
    w_m_dn   = (set_minutes_q == 7'd0) ? 7'd59 : set_minutes_q - 7'd1;
    w_load_h = (cur_hours > 5'd23) ? 5'd0 : cur_hours;
    w_load_m = (cur_minutes > 7'd59) ? 7'd0 : cur_minutes;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      set_strobe_q  <= 1'b0;
      set_hours_q   <= 5'd0;
      set_minutes_q <= 7'd0;
      blink_q       <= 1'b0;
      to_cnt_q      <= '0;
      blink_cnt_q   <= '0;
    end else begin
      set_strobe_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          blink_q     <= 1'b0;
          blink_cnt_q <= '0;
          to_cnt_q    <= '0;
          if (w_mode_p) begin
            state_q       <= ST_SET_HOURS;
            set_hours_q   <= w_load_h;
            set_minutes_q <= w_load_m;
          end
        end
        ST_SET_HOURS, ST_SET_MINUTES: begin
          if (w_mode_p) begin
            to_cnt_q    <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            if (state_q == ST_SET_HOURS) begin
              state_q <= ST_SET_MINUTES;
            end else begin
              state_q      <= ST_COMMIT;
              set_strobe_q <= 1'b1;
            end
          end else if (w_any_p || w_rep_up || w_rep_dn) begin
            to_cnt_q <= '0;
            if (w_any_p) begin
              blink_q     <= 1'b0;
              blink_cnt_q <= '0;
            end else if (blink_cnt_q == c_bl_w'(BLINK_CYCLES - 1)) begin
              blink_q     <= ~blink_q;
              blink_cnt_q <= '0;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            if (state_q == ST_SET_HOURS) begin
              if (w_step_up)      set_hours_q <= w_h_up;
              else if (w_step_dn) set_hours_q <= w_h_dn;
            end else begin
              if (w_step_up)      set_minutes_q <= w_m_up;
              else if (w_step_dn) set_minutes_q <= w_m_dn;
            end
          end else if (to_cnt_q == c_to_w'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the edit: values stay in the edit registers, no strobe
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (blink_cnt_q == c_bl_w'(BLINK_CYCLES - 1)) begin
              blink_q     <= ~blink_q;
              blink_cnt_q <= '0;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_RUN;
          blink_q     <= 1'b0;
          blink_cnt_q <= '0;
          to_cnt_q    <= '0;
        end
      endcase
    end
  end

  assign set_strobe  = set_strobe_q;
  assign set_hours   = set_hours_q;
  assign set_minutes = set_minutes_q;
  assign mode        = state_q;
  assign blink       = blink_q;

endmodule

`default_nettype wire

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Button-driven time-set sequencer for the digital clock.
- Owns the "set" interface of the minute and hour counters. Takes three raw push buttons (mode, inc, dec) and walks the user through hour edit, then minute edit.
- On completion, issues a single-cycle set strobe with the edited values to both counters. Abandons the edit on inactivity timeout.
- Sits between the front-panel buttons and the minute/hour counter blocks. Also drives display blink.

Parameters:
- TIMEOUT_CYCLES, 10000, idle clk cycles in an edit state before abort to RUN.
- BLINK_CYCLES, 500, clk cycles per blink half-period.
- REPEAT_DELAY, 500, hold cycles before the first auto-repeat step (AUTO_REPEAT_EN only).
- REPEAT_RATE, 100, cycles between repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- btn_mode  input  1  raw mode button, asynchronous, debounced externally.
- btn_inc  input  1  raw increment button.
- btn_dec  input  1  raw decrement button.
- cur_hours  input  5  live hours from hour counter, 0..23.
- cur_minutes  input  7  live minutes from minute counter, 0..59.
- set_strobe  output  1  one-cycle pulse; counters load set_hours/set_minutes.
- set_hours  output  5  edited hours value.
- set_minutes  output  7  edited minutes value.
- mode  output  2  0=RUN, 1=SET_HOURS, 2=SET_MINUTES, 3=COMMIT.
- blink  output  1  display blank phase for the field under edit.

Behaviour:
- Reset values (async, immediate): state RUN, mode=0, set_strobe=0, set_hours=0, set_minutes=0, blink=0. Sync flops, timeout counter and blink counter all cleared.
- Input path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detect → one-cycle press pulse.
  - The state/value update is visible after the 3rd rising clk edge following the button rising.
- FSM transitions:
  - RUN: mode press → SET_HOURS; same edge loads set_hours←cur_hours, set_minutes←cur_minutes. inc/dec ignored.
  - SET_HOURS: inc → set_hours+1, 23 wraps to 0; dec → set_hours-1, 0 wraps to 23. Mode press → SET_MINUTES.
  - SET_MINUTES: inc/dec on set_minutes with wrap 59↔0. Mode press → COMMIT.
  - COMMIT: set_strobe=1 for exactly this one cycle; next edge → RUN unconditionally. Button presses arriving during COMMIT are dropped.
- Simultaneous events:
  - mode with inc or dec on the same cycle: mode wins; step dropped.
  - inc with dec on the same cycle: both ignored.
- Timeout:
  - Counter clears on entry to SET_HOURS/SET_MINUTES and on any press pulse; increments otherwise.
  - At TIMEOUT_CYCLES-1 → RUN with no set_strobe. Edit registers retain their values; counters remain unchanged.
- set_hours/set_minutes hold their last value in RUN and are only meaningful while set_strobe=1.
- Blink: 0 in RUN and COMMIT. In edit states, toggles every BLINK_CYCLES; phase restarts at 0 on state entry and on each press.
- Arithmetic: internal steps computed at full width, then wrapped. Out-of-range cur_* values (>23 / >59) loaded in RUN are clamped to 0.
- Reset mid-edit: immediate return to RUN; no strobe generated.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- Defined: inc or dec held (sync level high, other button low) in an edit state produces one step on press, then a step after REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles until release. Each repeat step resets the timeout. Repeat counters clear on release or state change.
- Undefined: exactly one step per press; REPEAT_* parameters unused and no repeat logic is synthesized.

Test Plan:
- Reset asserted mid-SET_MINUTES with set_minutes=37 → mode=0 and set_strobe=0 immediately. No strobe after reset release.
- cur_hours=23, cur_minutes=59; press mode, inc, mode, inc, mode → exactly one set_strobe cycle with set_hours=0, set_minutes=0; mode returns to 0 on the next cycle.
- SET_HOURS with set_hours=0, one dec press → 23. SET_MINUTES with set_minutes=0, dec → 59.
- TIMEOUT_CYCLES=50: enter SET_HOURS, no presses → mode=0 after 50 cycles; set_strobe never asserted.
- mode and inc rising on the same cycle in SET_HOURS → state SET_MINUTES, set_hours unchanged. inc and dec together → no change.
- With CLOCK_SET_AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5: hold inc 40 cycles from set_minutes=10 → 15 (1 press step + 4 repeats at cycles 20, 25, 30, 35). Without the macro → 11.
